// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit line reads/writes from the write buffer onto a 64-bit,
// four-beat burst interface toward physical memory.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i,
  output logic [1:0]   dbg_state
);

  // Handshake: read_i/write_i are levels held until the one-cycle resp_o
  // pulse; on the memory side each resp_i=1 cycle accepts (write) or delivers
  // (read) exactly one beat, and resp_i outside READ/WRITE is ignored.
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t       state, state_n;
  logic [1:0]   cnt;
  logic [31:0]  addr_q;
  logic [255:0] wline_q;
  logic [255:0] asm_q;
  logic [255:0] line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      addr_q  <= 32'd0;
      wline_q <= 256'd0;
      asm_q   <= 256'd0;
      line_q  <= 256'd0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (write_i) begin
            wline_q <= line_i;
            addr_q  <= {address_i[31:5], 5'b0};
            cnt     <= 2'd0;
          end else if (read_i) begin
            addr_q  <= {address_i[31:5], 5'b0};
            cnt     <= 2'd0;
          end
        end
        READ: begin
          if (resp_i) begin
            asm_q[{cnt, 6'b0} +: 64] <= burst_i;
            // Publish the whole line only once it is complete, so line_o
            // never shows a half-assembled read.
            if (cnt == 2'd3)
              line_q <= {burst_i, asm_q[191:0]};
            cnt <= cnt + 2'd1;
          end
        end
        WRITE: begin
          if (resp_i)
            cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (write_i)     state_n = WRITE;
        else if (read_i) state_n = READ;
      end
      READ:    if (resp_i && cnt == 2'd3) state_n = DONE;
      WRITE:   if (resp_i && cnt == 2'd3) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = (state == WRITE) ? wline_q[{cnt, 6'b0} +: 64] : 64'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized and directed bench for cacheline_adaptor, checked every cycle
// against a transaction-level model of the line/burst conversion.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  cacheline_adaptor dut (
    .clk(clk), .reset(reset),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: tracks the pending transaction and received beats
  bit           m_rd, m_wr, m_resp;
  int           m_beats;
  logic [31:0]  m_addr;
  logic [255:0] m_line, m_wline;
  logic [63:0]  rq[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rd = 0; m_wr = 0; m_resp = 0; m_beats = 0;
      m_addr = '0; m_line = '0; m_wline = '0;
      rq.delete();
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_rd) begin
      if (resp_i) rq.push_back(burst_i);
      if (rq.size() == 4) begin
        m_line = {rq[3], rq[2], rq[1], rq[0]};
        rq.delete();
        m_rd = 0; m_resp = 1;
      end
    end else if (m_wr) begin
      if (resp_i) m_beats++;
      if (m_beats == 4) begin
        m_wr = 0; m_resp = 1;
      end
    end else if (write_i) begin
      m_wr = 1; m_beats = 0; m_wline = line_i;
      m_addr = {address_i[31:5], 5'b0};
    end else if (read_i) begin
      m_rd = 1;
      m_addr = {address_i[31:5], 5'b0};
    end
  end

  // compare process: inputs change 2ns after posedge, outputs sampled at negedge
  always @(negedge clk) begin
    chk("read_o", read_o, m_rd);
    chk("write_o", write_o, m_wr);
    chk("resp_o", resp_o, m_resp);
    chk("line_o", line_o, m_line);
    chk("address_o", address_o, m_addr);
    if (m_wr) chk("burst_o", burst_o, m_wline[64*m_beats +: 64]);
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic txn(input bit wr, input bit rd, input logic [31:0] a,
                     input logic [255:0] l, input bit gaps, input bit hold);
    int beats = 0;
    int g = 0;
    write_i = wr; read_i = rd; address_i = a; line_i = l;
    resp_i = 1'($urandom_range(0, 1));
    cyc();
    address_i = $urandom;
    line_i = {8{$urandom}};
    while (beats < 4) begin
      resp_i = gaps ? (($urandom_range(0, 2) != 0) || g > 20) : 1'b1;
      burst_i = {$urandom, $urandom};
      cyc();
      if (resp_i) beats++;
      g++;
    end
    resp_i = 1'($urandom_range(0, 1));
    write_i = 0;
    if (!hold) read_i = 0;
    cyc();
    resp_i = 0;
  endtask

  logic [63:0]  rd_beats [4];
  bit           wpat [7];
  int           acc;

  initial begin
    rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wpat = '{1, 0, 1, 0, 0, 1, 1};
    reset = 1; read_i = 0; write_i = 0; resp_i = 0;
    address_i = '0; line_i = '0; burst_i = '0;
    cyc(); cyc();
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_line_o", line_o, 256'd0);
    chk("rst_addr_o", address_o, 32'd0);
    reset = 0;
    cyc();

    // read, no gaps
    address_i = 32'h0000_1234; read_i = 1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = rd_beats[i];
      #1 chk("rd_addr", address_o, 32'h0000_1220);
      chk("rd_read_o", read_o, 1'b1);
      cyc();
    end
    resp_i = 0; read_i = 0;
    #1 chk("rd_resp", resp_o, 1'b1);
    chk("rd_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    cyc();
    #1 chk("rd_resp_gone", resp_o, 1'b0);

    // write with gaps
    line_i = {64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0002,
              64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0000};
    address_i = 32'hDEAD_BEEF; write_i = 1;
    cyc();
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      resp_i = wpat[i];
      #1 chk("wr_burst", burst_o, 64'hA5A5_0000_0000_0000 | 64'(acc));
      chk("wr_write_o", write_o, 1'b1);
      cyc();
      if (wpat[i]) acc++;
    end
    resp_i = 0; write_i = 0;
    #1 chk("wr_resp", resp_o, 1'b1);
    chk("wr_write_drop", write_o, 1'b0);
    chk("wr_line_kept", line_o[63:0], 64'h1111_1111_1111_1111);
    cyc();

    // simultaneous request: write first, held read follows
    txn(1, 1, 32'h0000_4000, {8{32'hCAFE_F00D}}, 1, 1);
    #1 chk("sim_idle", read_o, 1'b0);
    txn(0, 1, 32'h0000_4000, '0, 1, 0);

    // back-to-back reads and spurious strobes in IDLE
    txn(0, 1, 32'h0001_0040, '0, 0, 1);
    txn(0, 1, 32'h0001_0080, '0, 1, 0);
    resp_i = 1; cyc(); cyc(); resp_i = 0; cyc();

    // reset mid-burst
    address_i = 32'h0000_2000; read_i = 1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      resp_i = 1; burst_i = {$urandom, $urandom}; cyc();
    end
    reset = 1; resp_i = 0;
    #1 chk("mid_rst_read_o", read_o, 1'b0);
    chk("mid_rst_resp_o", resp_o, 1'b0);
    chk("mid_rst_line_o", line_o, 256'd0);
    chk("mid_rst_addr_o", address_o, 32'd0);
    read_i = 0;
    cyc();
    reset = 0;
    cyc();
    txn(0, 1, 32'h0000_2000, '0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit wr, rd, hold;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = rd ? 1'($urandom_range(0, 1)) : 1'b0;
      txn(wr, rd, $urandom, {8{$urandom}}, 1'($urandom_range(0, 1)), hold);
      if (!hold && $urandom_range(0, 2) == 0) begin
        resp_i = 1'($urandom_range(0, 1)); cyc(); resp_i = 0;
      end
    end
    read_i = 0; write_i = 0;
    repeat (8) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
